// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit bus master.
// Contents: the pipeline access-mask encodings, the FSM state type, and helpers
// that give the byte-enable footprint of a mask and decide whether a mask is legal.
package lsu_pkg;

    localparam logic [2:0] MASK_B  = 3'b000;
    localparam logic [2:0] MASK_H  = 3'b001;
    localparam logic [2:0] MASK_W  = 3'b010;
    localparam logic [2:0] MASK_BU = 3'b100;
    localparam logic [2:0] MASK_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ0  = 3'd1,
        WAIT0 = 3'd2,
        REQ1  = 3'd3,
        WAIT1 = 3'd4,
        RESP  = 3'd5
    } state_t;

    // Byte-enable footprint of an access at offset 0.
    function automatic logic [3:0] size_be(input logic [2:0] mask);
        logic [3:0] be;
        case (mask)
            MASK_B, MASK_BU: be = 4'b0001;
            MASK_H, MASK_HU: be = 4'b0011;
            MASK_W:          be = 4'b1111;
            default:         be = 4'b0000;
        endcase
        return be;
    endfunction

    // Unsigned variants exist only for loads; a store has nothing to extend.
    function automatic logic mask_legal(input logic [2:0] mask, input logic we);
        logic ok;
        case (mask)
            MASK_B, MASK_H, MASK_W: ok = 1'b1;
            MASK_BU, MASK_HU:       ok = ~we;
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment and extension (purely combinational).
// Ports:
//   rdata_pair - {rdata1[23:0], rdata0}: the two fetched words; the top byte of
//                rdata1 can never land in the result, so it is not carried here
//   off        - byte offset of the original access within the first word
//   mask       - pipeline access mask selecting width and sign/zero extension
//   ldata      - right-aligned, extended load data
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [55:0] rdata_pair,
    input  logic [1:0]  off,
    input  logic [2:0]  mask,
    output logic [31:0] ldata
);

    logic [31:0] raw_s;

    // Shift the word pair right by the byte offset.
    always_comb begin
        raw_s = rdata_pair[31:0];
        case (off)
            2'd0:    raw_s = rdata_pair[31:0];
            2'd1:    raw_s = rdata_pair[39:8];
            2'd2:    raw_s = rdata_pair[47:16];
            2'd3:    raw_s = rdata_pair[55:24];
            default: raw_s = rdata_pair[31:0];
        endcase
    end

    // Extend the selected byte/halfword according to the mask.
    always_comb begin
        ldata = 32'h0000_0000;
        case (mask)
            MASK_B:  ldata = {{24{raw_s[7]}}, raw_s[7:0]};
            MASK_H:  ldata = {{16{raw_s[15]}}, raw_s[15:0]};
            MASK_W:  ldata = raw_s;
            MASK_BU: ldata = {24'h00_0000, raw_s[7:0]};
            MASK_HU: ldata = {16'h0000, raw_s[15:0]};
            default: ldata = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/lsu_bus_master.sv
// Load/store unit bus master: turns a pipeline load/store into one or two
// word-aligned memory transactions with byte enables, reassembling and
// extending load data.
// Ports:
//   clk, rst                         - clock, asynchronous active-high reset
//   req_valid/req_ready              - pipeline request handshake
//   req_we/req_mask/req_addr/req_wdata - request fields, captured at acceptance
//   resp_valid/resp_rdata/resp_err   - one-cycle completion pulse and result
//   mem_req/mem_we/mem_addr/mem_be/mem_wdata - registered bus request, held until mem_gnt
//   mem_gnt                          - bus accepted the request this cycle
//   mem_rvalid/mem_rdata             - in-order response, at least one cycle after grant
module lsu_bus_master
    import lsu_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int SPLIT_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_mask,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);

    state_t            state_r, state_nxt_s;
    logic              req_ready_r, req_ready_nxt_s;
    logic              resp_valid_r, resp_valid_nxt_s;
    logic              resp_err_r, resp_err_nxt_s;
    logic [31:0]       resp_rdata_r, resp_rdata_nxt_s;
    logic              mem_req_r, mem_req_nxt_s;
    logic              mem_we_r, mem_we_nxt_s;
    logic [ADDR_W-1:0] mem_addr_r, mem_addr_nxt_s;
    logic [3:0]        mem_be_r, mem_be_nxt_s;
    logic [31:0]       mem_wdata_r, mem_wdata_nxt_s;
    // Captured request context
    logic              we_r, we_nxt_s;
    logic [2:0]        mask_r, mask_nxt_s;
    logic [1:0]        off_r, off_nxt_s;
    logic              split_r, split_nxt_s;
    logic [3:0]        be_hi_r, be_hi_nxt_s;
    logic [31:0]       wd_hi_r, wd_hi_nxt_s;
    logic [ADDR_W-1:0] addr1_r, addr1_nxt_s;
    logic [31:0]       rdata0_r, rdata0_nxt_s;

    logic [1:0]        off_in_s;
    logic [7:0]        be64_s;
    logic [31:0]       wmask_s;
    logic [63:0]       wd64_s;
    logic              cross_s;
    logic              err_s;
    logic [55:0]       pair_s;
    logic [31:0]       ldata_s;

    assign off_in_s = req_addr[1:0];
    assign be64_s   = {4'b0000, size_be(req_mask)} << off_in_s;
    assign wd64_s   = {32'h0000_0000, wmask_s} << {off_in_s, 3'b000};
    // An access "crosses" when its byte lanes spill into the next word.
    assign cross_s  = |be64_s[7:4];
    assign err_s    = ~mask_legal(req_mask, req_we) | (cross_s & (SPLIT_EN == 0));

    // Keep only the store bytes the mask asks for.
    always_comb begin
        wmask_s = req_wdata;
        case (req_mask[1:0])
            2'b00:   wmask_s = {24'h00_0000, req_wdata[7:0]};
            2'b01:   wmask_s = {16'h0000, req_wdata[15:0]};
            default: wmask_s = req_wdata;
        endcase
    end

    // In WAIT1 the second word is live on the bus; otherwise only the first matters.
    assign pair_s = (state_r == WAIT1) ? {mem_rdata[23:0], rdata0_r}
                                       : {24'h00_0000, mem_rdata};

    lsu_load_align u_align (
        .rdata_pair (pair_s),
        .off        (off_r),
        .mask       (mask_r),
        .ldata      (ldata_s)
    );

    // Next-state and next-output logic for the transaction FSM.
    always_comb begin
        state_nxt_s      = state_r;
        req_ready_nxt_s  = req_ready_r;
        resp_valid_nxt_s = 1'b0;
        resp_err_nxt_s   = resp_err_r;
        resp_rdata_nxt_s = resp_rdata_r;
        mem_req_nxt_s    = mem_req_r;
        mem_we_nxt_s     = mem_we_r;
        mem_addr_nxt_s   = mem_addr_r;
        mem_be_nxt_s     = mem_be_r;
        mem_wdata_nxt_s  = mem_wdata_r;
        we_nxt_s         = we_r;
        mask_nxt_s       = mask_r;
        off_nxt_s        = off_r;
        split_nxt_s      = split_r;
        be_hi_nxt_s      = be_hi_r;
        wd_hi_nxt_s      = wd_hi_r;
        addr1_nxt_s      = addr1_r;
        rdata0_nxt_s     = rdata0_r;

        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    req_ready_nxt_s = 1'b0;
                    we_nxt_s        = req_we;
                    mask_nxt_s      = req_mask;
                    off_nxt_s       = off_in_s;
                    split_nxt_s     = cross_s;
                    be_hi_nxt_s     = be64_s[7:4];
                    wd_hi_nxt_s     = wd64_s[63:32];
                    addr1_nxt_s     = {req_addr[ADDR_W-1:2] + (ADDR_W-2)'(1'b1), 2'b00};
                    if (err_s) begin
                        state_nxt_s      = RESP;
                        resp_valid_nxt_s = 1'b1;
                        resp_err_nxt_s   = 1'b1;
                        resp_rdata_nxt_s = 32'h0000_0000;
                    end else begin
                        state_nxt_s     = REQ0;
                        mem_req_nxt_s   = 1'b1;
                        mem_we_nxt_s    = req_we;
                        mem_addr_nxt_s  = {req_addr[ADDR_W-1:2], 2'b00};
                        mem_be_nxt_s    = be64_s[3:0];
                        mem_wdata_nxt_s = wd64_s[31:0];
                    end
                end else begin
                    req_ready_nxt_s = 1'b1;
                end
            end
            REQ0: begin
                if (mem_gnt) begin
                    state_nxt_s   = WAIT0;
                    mem_req_nxt_s = 1'b0;
                end else begin
                    mem_req_nxt_s = 1'b1;
                end
            end
            WAIT0: begin
                if (mem_rvalid) begin
                    rdata0_nxt_s = mem_rdata;
                    if (split_r) begin
                        state_nxt_s     = REQ1;
                        mem_req_nxt_s   = 1'b1;
                        mem_addr_nxt_s  = addr1_r;
                        mem_be_nxt_s    = be_hi_r;
                        mem_wdata_nxt_s = wd_hi_r;
                    end else begin
                        state_nxt_s      = RESP;
                        resp_valid_nxt_s = 1'b1;
                        resp_err_nxt_s   = 1'b0;
                        resp_rdata_nxt_s = we_r ? 32'h0000_0000 : ldata_s;
                    end
                end else begin
                    state_nxt_s = WAIT0;
                end
            end
            REQ1: begin
                if (mem_gnt) begin
                    state_nxt_s   = WAIT1;
                    mem_req_nxt_s = 1'b0;
                end else begin
                    mem_req_nxt_s = 1'b1;
                end
            end
            WAIT1: begin
                if (mem_rvalid) begin
                    state_nxt_s      = RESP;
                    resp_valid_nxt_s = 1'b1;
                    resp_err_nxt_s   = 1'b0;
                    resp_rdata_nxt_s = we_r ? 32'h0000_0000 : ldata_s;
                end else begin
                    state_nxt_s = WAIT1;
                end
            end
            RESP: begin
                state_nxt_s      = IDLE;
                req_ready_nxt_s  = 1'b1;
                resp_err_nxt_s   = 1'b0;
                resp_rdata_nxt_s = 32'h0000_0000;
            end
            default: begin
                state_nxt_s      = IDLE;
                req_ready_nxt_s  = 1'b1;
                resp_err_nxt_s   = 1'b0;
                resp_rdata_nxt_s = 32'h0000_0000;
                mem_req_nxt_s    = 1'b0;
            end
        endcase
    end

    // State and registered-output flops; reset aborts any transaction at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            resp_rdata_r <= 32'h0000_0000;
            mem_req_r    <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= {ADDR_W{1'b0}};
            mem_be_r     <= 4'b0000;
            mem_wdata_r  <= 32'h0000_0000;
            we_r         <= 1'b0;
            mask_r       <= 3'b000;
            off_r        <= 2'b00;
            split_r      <= 1'b0;
            be_hi_r      <= 4'b0000;
            wd_hi_r      <= 32'h0000_0000;
            addr1_r      <= {ADDR_W{1'b0}};
            rdata0_r     <= 32'h0000_0000;
        end else begin
            state_r      <= state_nxt_s;
            req_ready_r  <= req_ready_nxt_s;
            resp_valid_r <= resp_valid_nxt_s;
            resp_err_r   <= resp_err_nxt_s;
            resp_rdata_r <= resp_rdata_nxt_s;
            mem_req_r    <= mem_req_nxt_s;
            mem_we_r     <= mem_we_nxt_s;
            mem_addr_r   <= mem_addr_nxt_s;
            mem_be_r     <= mem_be_nxt_s;
            mem_wdata_r  <= mem_wdata_nxt_s;
            we_r         <= we_nxt_s;
            mask_r       <= mask_nxt_s;
            off_r        <= off_nxt_s;
            split_r      <= split_nxt_s;
            be_hi_r      <= be_hi_nxt_s;
            wd_hi_r      <= wd_hi_nxt_s;
            addr1_r      <= addr1_nxt_s;
            rdata0_r     <= rdata0_nxt_s;
        end
    end

    assign req_ready  = req_ready_r;
    assign resp_valid = resp_valid_r;
    assign resp_err   = resp_err_r;
    assign resp_rdata = resp_rdata_r;
    assign mem_req    = mem_req_r;
    assign mem_we     = mem_we_r;
    assign mem_addr   = mem_addr_r;
    assign mem_be     = mem_be_r;
    assign mem_wdata  = mem_wdata_r;

endmodule
